// File: rtl/mmem_rd_burst.sv
// mmem_rd_burst: burst read sequencer in front of the main-memory read port.
// Takes (base, len) commands, issues len consecutive reads, captures the returned
// words into a local FIFO and presents them on a valid/ready stream. Reads are only
// issued when a FIFO slot is guaranteed for their return data, so backpressure on
// the output stream never loses words.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cmd_val/rdy     command handshake (rdy only while idle)
//   cmd_base_addr   first read address
//   cmd_len         burst length in words, 0 = empty burst
//   mmem_rd_en      read enable towards mmem
//   mmem_rd_addr    read address towards mmem
//   mmem_data_out   read data from mmem, RD_LAT cycles after mmem_rd_en
//   out_val/rdy     output word handshake
//   out_data        output word
//   out_last        final word of the burst
//   busy            burst in progress
//   done            one-cycle pulse when a burst completes
module mmem_rd_burst #(
  parameter int unsigned ADDR_WDT   = 16,
  parameter int unsigned DATA_WDT   = 64,
  parameter int unsigned LEN_WDT    = 16,
  parameter int unsigned RD_LAT     = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_val,
  output logic                cmd_rdy,
  input  logic [ADDR_WDT-1:0] cmd_base_addr,
  input  logic [LEN_WDT-1:0]  cmd_len,
  output logic                mmem_rd_en,
  output logic [ADDR_WDT-1:0] mmem_rd_addr,
  input  logic [DATA_WDT-1:0] mmem_data_out,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [DATA_WDT-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e              state_q, state_d;
  logic [ADDR_WDT-1:0] addr_q, addr_d;
  logic [LEN_WDT-1:0]  rem_q, rem_d;
  logic                done_q, done_d;

  // In-flight read tracking, one stage per cycle of memory latency.
  logic [RD_LAT-1:0]   pipe_val_q, pipe_val_d;
  logic [RD_LAT-1:0]   pipe_last_q, pipe_last_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;

  // Return FIFO; the top bit of each entry is the last-word flag.
  logic [DATA_WDT:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                issue, issue_last, credit_ok;
  logic                push, push_last, pop;
  logic [OCC_W-1:0]    occ;

  assign push      = pipe_val_q[RD_LAT-1];
  assign push_last = pipe_last_q[RD_LAT-1];
  assign out_val   = (count_q != '0);
  assign pop       = out_val & out_rdy;
  assign out_data  = mem_q[rd_ptr_q][DATA_WDT-1:0];
  assign out_last  = out_val & mem_q[rd_ptr_q][DATA_WDT];

  // Slots already claimed after this cycle's pop; a word being pushed this
  // cycle is still counted in inflight_q, so it is not double counted.
  assign occ       = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign credit_ok = (occ < OCC_W'(FIFO_DEPTH));

  assign cmd_rdy      = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign mmem_rd_en   = issue;
  assign mmem_rd_addr = addr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_val) begin
          if (cmd_len != '0) begin
            addr_d  = cmd_base_addr;
            rem_d   = cmd_len;
            state_d = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (rem_q == LEN_WDT'(1));
          addr_d     = addr_q + ADDR_WDT'(1);
          rem_d      = rem_q - LEN_WDT'(1);
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave as the final word is popped so done lands the following cycle.
        if (inflight_q == '0 && count_q == CNT_W'(pop)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pipe_val_d     = pipe_val_q << 1;
    pipe_last_d    = pipe_last_q << 1;
    pipe_val_d[0]  = issue;
    pipe_last_d[0] = issue_last;
    inflight_d     = inflight_q + CNT_W'(issue) - CNT_W'(push);
    count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      pipe_val_q  <= '0;
      pipe_last_q <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      pipe_val_q  <= pipe_val_d;
      pipe_last_q <= pipe_last_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Data storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= {push_last, mmem_data_out};
  end

endmodule
